// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults, width helper and derived widths for the
//               scoreboarded register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        // A one-entry space still needs a one-bit field.
        return (result < 1) ? 1 : result;
    endfunction

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_NREG       = 32;
    localparam int DEF_NRD        = 2;
    localparam int DEF_PIPE_DEPTH = 3;

    localparam int DEF_ADDR_W = clog2(DEF_NREG);
    localparam int DEF_CNT_W  = clog2(DEF_PIPE_DEPTH + 1);

endpackage

`default_nettype wire

// File: rtl/pending_counter.sv
// ============================================================================
// Module      : pending_counter
// Description : Saturating up/down count of outstanding writes to one register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pending_counter
    import regfile_pkg::*;
#(
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter int CNT_W      = clog2(PIPE_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             nz,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(PIPE_DEPTH);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_empty;

    assign w_empty = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (inc && dec && !w_empty) begin
            cnt_d = cnt_q;
        end else if (inc && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !w_empty) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign nz        = !w_empty;
    assign underflow = dec && w_empty && !inc;

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : N-read register file with write-through bypass and a
//               per-register pending-write scoreboard driving issue stall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NREG       = DEF_NREG,
    parameter int NRD        = DEF_NRD,
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter int ZERO_REG   = 0,
    parameter int ADDR_W     = clog2(NREG),
    parameter int CNT_W      = clog2(PIPE_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    input  logic [NRD-1:0]        rd_used,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  iss_valid,
    input  logic                  iss_wen,
    input  logic [ADDR_W-1:0]     iss_dst,
    output logic                  iss_stall,
    input  logic                  wb_valid,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic [NREG-1:0]       busy,
    output logic                  err_underflow
);

    localparam bit C_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  w_cnt  [NREG];
    logic [NREG-1:0]   w_uf;
    logic [NRD-1:0]    w_src_haz;
    logic              w_dst_sat;
    logic              w_wb_zero;
    logic              w_dst_zero;
    logic              w_issue_fire;
    logic              err_underflow_q;
    logic              err_underflow_d;

    assign w_wb_zero  = C_ZERO && (wb_addr == '0);
    assign w_dst_zero = C_ZERO && (iss_dst == '0);

    always_comb begin
        regs_d = regs_q;
        if (wb_valid && !w_wb_zero) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic              w_zero;
            logic              w_hit;

            assign w_addr = rd_addr[i*ADDR_W +: ADDR_W];
            assign w_zero = C_ZERO && (w_addr == '0);
            assign w_hit  = wb_valid && (wb_addr == w_addr);

            assign rd_data[i*DATA_W +: DATA_W] = w_zero ? '0 :
                                                 w_hit  ? wb_data : regs_q[w_addr];

            // The final pending write landing this cycle is bypassed, so no stall.
            assign w_src_haz[i] = rd_used[i] && !w_zero && (w_cnt[w_addr] != '0) &&
                                  !(w_hit && (w_cnt[w_addr] == CNT_W'(1)));
        end
    endgenerate

    assign w_dst_sat = iss_wen && !w_dst_zero &&
                       (w_cnt[iss_dst] == CNT_W'(PIPE_DEPTH)) &&
                       !(wb_valid && (wb_addr == iss_dst));

    assign iss_stall    = iss_valid && ((|w_src_haz) || w_dst_sat);
    assign w_issue_fire = iss_valid && !iss_stall && iss_wen && !w_dst_zero;

    generate
        for (genvar r = 0; r < NREG; r++) begin : g_cnt
            logic w_zero_r;

            assign w_zero_r = C_ZERO && (r == 0);

            pending_counter #(
                .PIPE_DEPTH (PIPE_DEPTH),
                .CNT_W      (CNT_W)
            ) u_pending_counter (
                .clk       (clk),
                .reset     (reset),
                .inc       (w_issue_fire && (iss_dst == ADDR_W'(r))),
                .dec       (wb_valid && !w_zero_r && (wb_addr == ADDR_W'(r))),
                .cnt       (w_cnt[r]),
                .nz        (busy[r]),
                .underflow (w_uf[r])
            );
        end
    endgenerate

    assign err_underflow_d = err_underflow_q || (|w_uf);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_underflow_q <= 1'b0;
        end else begin
            err_underflow_q <= err_underflow_d;
        end
    end

    assign err_underflow = err_underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Directed table-driven bench for regfile_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int NRD    = 2;
    localparam int ADDR_W = 5;

    logic                  clk;
    logic                  reset;
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD-1:0]        rd_used;
    logic [NRD*DATA_W-1:0] rd_data;
    logic                  iss_valid;
    logic                  iss_wen;
    logic [ADDR_W-1:0]     iss_dst;
    logic                  iss_stall;
    logic                  wb_valid;
    logic [ADDR_W-1:0]     wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic [NREG-1:0]       busy;
    logic                  err_underflow;

    int checks;
    int errors;

    regfile_scoreboard #(
        .DATA_W     (DATA_W),
        .NREG       (NREG),
        .NRD        (NRD),
        .PIPE_DEPTH (3),
        .ZERO_REG   (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_addr       (rd_addr),
        .rd_used       (rd_used),
        .rd_data       (rd_data),
        .iss_valid     (iss_valid),
        .iss_wen       (iss_wen),
        .iss_dst       (iss_dst),
        .iss_stall     (iss_stall),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [1:0]  used;
        logic        iv;
        logic        iw;
        logic [4:0]  dst;
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        estall;
        logic [31:0] ebusy;
        logic        eerr;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    function automatic vec_t mk(
        input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] used,
        input logic iv, input logic iw, input logic [4:0] dst,
        input logic wv, input logic [4:0] wa, input logic [31:0] wd,
        input logic [31:0] e0, input logic [31:0] e1, input logic estall,
        input logic [31:0] ebusy, input logic eerr);
        vec_t v;
        v.a0 = a0; v.a1 = a1; v.used = used; v.iv = iv; v.iw = iw; v.dst = dst;
        v.wv = wv; v.wa = wa; v.wd = wd; v.e0 = e0; v.e1 = e1;
        v.estall = estall; v.ebusy = ebusy; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        rd_addr   = '0;
        rd_used   = '0;
        iss_valid = 1'b0;
        iss_wen   = 1'b0;
        iss_dst   = '0;
        wb_valid  = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        rd_addr   = {v.a1, v.a0};
        rd_used   = v.used;
        iss_valid = v.iv;
        iss_wen   = v.iw;
        iss_dst   = v.dst;
        wb_valid  = v.wv;
        wb_addr   = v.wa;
        wb_data   = v.wd;
        #1;
        chk($sformatf("v%0d rd0", idx), rd_data[31:0], v.e0);
        chk($sformatf("v%0d rd1", idx), rd_data[63:32], v.e1);
        chk($sformatf("v%0d stall", idx), {31'd0, iss_stall}, {31'd0, v.estall});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d busy", idx), busy, v.ebusy);
        chk($sformatf("v%0d err", idx), {31'd0, err_underflow}, {31'd0, v.eerr});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive_idle();

        //          a0 a1 used iv iw dst wv wa wd             e0            e1          stall busy         err
        // RAW on r5, resolved by same-cycle writeback
        tbl[0]  = mk(0, 0, 2'b00, 1, 1, 5, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h20, 0);
        tbl[1]  = mk(5, 0, 2'b01, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h20, 0);
        tbl[2]  = mk(5, 0, 2'b01, 1, 0, 0, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0, 32'h0,  0);
        tbl[3]  = mk(5, 0, 2'b01, 1, 0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 32'h0,        0, 32'h0,  0);
        // WAW saturation on r3
        tbl[4]  = mk(0, 0, 2'b00, 1, 1, 3, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h8,  0);
        tbl[5]  = mk(0, 0, 2'b00, 1, 1, 3, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h8,  0);
        tbl[6]  = mk(0, 0, 2'b00, 1, 1, 3, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h8,  0);
        tbl[7]  = mk(0, 0, 2'b00, 1, 1, 3, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h8,  0);
        tbl[8]  = mk(0, 0, 2'b00, 0, 0, 0, 1, 3, 32'hA0,       32'h0,        32'h0,        0, 32'h8,  0);
        tbl[9]  = mk(0, 0, 2'b00, 1, 1, 3, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h8,  0);
        tbl[10] = mk(0, 0, 2'b00, 1, 1, 3, 0, 0, 32'h0,        32'h0,        32'h0,        1, 32'h8,  0);
        // drain r3 while port 1 reads it: stalls until the last write lands
        tbl[11] = mk(0, 3, 2'b10, 1, 0, 0, 1, 3, 32'h31,       32'h0,        32'h31,       1, 32'h8,  0);
        tbl[12] = mk(0, 3, 2'b10, 1, 0, 0, 1, 3, 32'h32,       32'h0,        32'h32,       1, 32'h8,  0);
        tbl[13] = mk(0, 3, 2'b10, 1, 0, 0, 1, 3, 32'h33,       32'h0,        32'h33,       0, 32'h0,  0);
        // simultaneous issue and writeback on r7
        tbl[14] = mk(0, 0, 2'b00, 1, 1, 7, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h80, 0);
        tbl[15] = mk(0, 0, 2'b00, 1, 1, 7, 1, 7, 32'h55,       32'h0,        32'h0,        0, 32'h80, 0);
        tbl[16] = mk(7, 0, 2'b00, 0, 0, 0, 0, 0, 32'h0,        32'h55,       32'h0,        0, 32'h80, 0);
        tbl[17] = mk(0, 7, 2'b00, 0, 0, 0, 1, 7, 32'h77,       32'h0,        32'h77,       0, 32'h0,  0);
        // stray writeback to idle r9
        tbl[18] = mk(9, 0, 2'b00, 0, 0, 0, 1, 9, 32'h12345678, 32'h12345678, 32'h0,        0, 32'h0,  1);
        tbl[19] = mk(9, 5, 2'b11, 1, 0, 0, 0, 0, 32'h0,        32'h12345678, 32'hDEADBEEF, 0, 32'h0,  1);
        // register 0 is hardwired
        tbl[20] = mk(0, 0, 2'b11, 1, 1, 0, 1, 0, 32'h1234,     32'h0,        32'h0,        0, 32'h0,  1);
        tbl[21] = mk(0, 0, 2'b11, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h0,  1);

        do_reset();

        // Post-reset sweep of every register on both ports.
        for (int r = 0; r < NREG; r++) begin
            @(negedge clk);
            rd_addr   = {5'(31 - r), 5'(r)};
            rd_used   = 2'b11;
            iss_valid = 1'b1;
            iss_wen   = 1'b0;
            #1;
            chk($sformatf("reset rd0 r%0d", r), rd_data[31:0], 32'h0);
            chk($sformatf("reset rd1 r%0d", 31 - r), rd_data[63:32], 32'h0);
            chk($sformatf("reset stall r%0d", r), {31'd0, iss_stall}, 32'h0);
        end
        chk("reset busy", busy, 32'h0);
        chk("reset err", {31'd0, err_underflow}, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            apply(i, tbl[i]);
        end

        // Sticky underflow across idle cycles, cleared by reset.
        @(negedge clk);
        drive_idle();
        repeat (10) @(posedge clk);
        #1;
        chk("err sticky", {31'd0, err_underflow}, 32'h1);

        do_reset();
        @(negedge clk);
        rd_addr = {5'd7, 5'd9};
        rd_used = 2'b11;
        iss_valid = 1'b1;
        #1;
        chk("reset2 err", {31'd0, err_underflow}, 32'h0);
        chk("reset2 busy", busy, 32'h0);
        chk("reset2 r9", rd_data[31:0], 32'h0);
        chk("reset2 r7", rd_data[63:32], 32'h0);
        chk("reset2 stall", {31'd0, iss_stall}, 32'h0);

        // Stall stays low when nothing is presented, even with a saturated dst.
        @(negedge clk);
        drive_idle();
        iss_valid = 1'b1;
        iss_wen   = 1'b1;
        iss_dst   = 5'd12;
        repeat (3) @(posedge clk);
        #1;
        chk("sat r12 busy", busy, 32'h1000);
        @(negedge clk);
        iss_valid = 1'b0;
        rd_addr   = {5'd0, 5'd12};
        rd_used   = 2'b01;
        #1;
        chk("no valid no stall", {31'd0, iss_stall}, 32'h0);
        iss_valid = 1'b1;
        #1;
        chk("sat r12 stall", {31'd0, iss_stall}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the fixed 2-read/1-write 32x32 register file used by the 5-stage datapath. Adds:
- N read ports.
- Write-through bypass, so writeback data is visible on the same cycle's reads.
- Per-register pending-write scoreboard that generates an issue stall for RAW and WAW-saturation hazards.

It sits between the decode stage (read ports, issue port) and the WB stage (write port). It removes the need for compiler-inserted NOPs.

Parameters:
DATA_W, 32, register width in bits
NREG, 32, number of architectural registers; ADDR_W = clog2(NREG)
NRD, 2, number of read ports
PIPE_DEPTH, 3, max outstanding writes per register; CNT_W = clog2(PIPE_DEPTH+1)
ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes, never goes busy

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
rd_addr  in  NRD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rd_used  in  NRD  port i source is actually consumed by the issuing instruction
rd_data  out  NRD*DATA_W  read data, combinational, with bypass
iss_valid  in  1  decode presents an instruction
iss_wen  in  1  the instruction writes a destination
iss_dst  in  ADDR_W  destination register
iss_stall  out  1  combinational; the instruction must not issue this cycle
wb_valid  in  1  writeback strobe
wb_addr  in  ADDR_W  writeback register
wb_data  in  DATA_W  writeback data
busy  out  NREG  bit r = pending count of r is nonzero (registered)
err_underflow  out  1  sticky; a writeback arrived for a register with zero pending

Behaviour:
- Clock is clk; reset is synchronous and active-high. On a reset edge:
  - all registers go to 0;
  - all pending counters go to 0, so busy = 0;
  - err_underflow goes to 0.
  - Writebacks still in flight at reset are the caller's responsibility to flush. A later stray wb falls under the underflow rule below.
- Read: rd_data[i] = wb_data when wb_valid && wb_addr == rd_addr[i]; otherwise it is the stored value.
  - With ZERO_REG=1 and rd_addr[i] == 0, rd_data[i] = 0 regardless of the bypass.
- Write: on a clk edge with wb_valid, reg[wb_addr] <= wb_data. Ignored for address 0 when ZERO_REG=1.
- Source hazard for port i: rd_used[i] && cnt[rd_addr[i]] != 0 && !(wb_valid && wb_addr == rd_addr[i] && cnt[rd_addr[i]] == 1).
  - The last outstanding write being written back this cycle is bypassed, so it does not stall.
- Destination saturation: iss_wen && cnt[iss_dst] == PIPE_DEPTH && !(wb_valid && wb_addr == iss_dst).
- iss_stall = iss_valid && (any source hazard || destination saturation).
  - iss_stall is 0 whenever iss_valid is 0.
  - A ZERO_REG register 0 never causes either hazard.
- Issue fires when iss_valid && !iss_stall && iss_wen, and iss_dst is not the ZERO_REG register 0.
- Counter update per register r, at each clk edge:
  - +1 if issue fires on r.
  - -1 if wb_valid on r with cnt != 0.
  - Both in the same cycle: net unchanged.
  - cnt never exceeds PIPE_DEPTH and never wraps below 0.
- Underflow: wb_valid on r with cnt[r] == 0 and no same-cycle issue to r.
  - Data is still written.
  - err_underflow <= 1 and holds until reset.
- Self-dependency: an instruction whose source equals its own dst is evaluated against the pre-issue count.
- busy reflects the counters after the edge, i.e. one cycle after issue.
- Latency: read 0 cycles (combinational), write 1 edge, stall 0 cycles (combinational).

Decomposition:
- Shared package regfile_pkg holds:
  - default constants DATA_W, NREG, NRD, PIPE_DEPTH;
  - a clog2 function;
  - the derived ADDR_W and CNT_W.
- One sub-module, pending_counter: a saturating CNT_W up/down counter with inc, dec, sync reset and outputs cnt, nz, underflow. It is instantiated NREG times via generate.
- The storage array, bypass muxes and stall logic stay in the top level.

Test Plan:
1. Assert reset 1 cycle, then read all 32 registers on 2 ports -> every rd_data = 0, busy = 0, err_underflow = 0, iss_stall = 0.
2. Issue dst r5. Next cycle present rd_addr[0]=5, rd_used=01 with no wb -> iss_stall=1, busy[5]=1. Then the same read with wb_valid, wb_addr=5, wb_data=0xDEADBEEF -> iss_stall=0, rd_data[0]=0xDEADBEEF on that cycle, busy[5]=0 after the edge.
3. PIPE_DEPTH=3: issue dst r3 on 3 consecutive cycles -> a 4th issue to r3 gives iss_stall=1. Then one wb to r3 -> count 2, the 4th issue proceeds, count back to 3.
4. cnt[r7]=1, then issue dst r7 and wb r7=0x55 in the same cycle -> no stall, busy[7] stays 1, reg r7 = 0x55.
5. wb r9=0x12345678 with cnt[r9]=0 -> r9 reads 0x12345678 and err_underflow=1, still 1 after 10 idle cycles, 0 after reset.
6. ZERO_REG=1: wb r0=0x1234 and issue dst r0 -> r0 reads 0, busy[0]=0, and a read of r0 with rd_used set never stalls.
